// File: rtl/unary_win_counter_if.sv
// Handshake/bus bundle between a unary_win_counter and its driver/consumer.
//   start     : request a new accumulation window
//   clear     : synchronous abort back to IDLE
//   in        : stochastic bitstream being counted
//   out_ready : consumer accepts result
//   busy      : counter is accumulating
//   out_valid : result is valid and held
//   result    : ones count of the last completed window (CWID+1 bits)
interface unary_win_counter_if #(
  parameter int unsigned CWID = 8
);
  logic            start;
  logic            clear;
  logic            in;
  logic            out_ready;
  logic            busy;
  logic            out_valid;
  logic [CWID:0]   result;

  modport master (
    output start, clear, in, out_ready,
    input  busy, out_valid, result
  );

  modport slave (
    input  start, clear, in, out_ready,
    output busy, out_valid, result
  );
endinterface

// File: rtl/unary_win_counter.sv
// Counts the ones of a 1-bit stochastic stream over a window of 2^CWID cycles
// and presents the count through a valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : unary_win_counter_if slave (start/clear/in/out_ready in,
//           busy/out_valid/result out)
module unary_win_counter #(
  parameter int unsigned CWID = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unary_win_counter_if.slave   bus
);

  localparam int unsigned ACC_W = CWID + 1;
  localparam logic [CWID-1:0] CYC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CWID-1:0]    cyc_q, cyc_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               busy_q, out_valid_q;

  // State and datapath registers; busy/out_valid are decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cyc_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cyc_q       <= cyc_d;
      result_q    <= result_d;
      busy_q      <= (state_d == RUN);
      out_valid_q <= (state_d == HOLD);
    end
  end

  // Next-state and datapath update; clear overrides everything except result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cyc_d    = cyc_q;
    result_d = result_q;

    if (bus.clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cyc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = RUN;
            acc_d   = '0;
            cyc_d   = '0;
          end
        end
        RUN: begin
          acc_d = acc_q + ACC_W'(bus.in);
          cyc_d = cyc_q + CWID'(1);
          // Final sample of the window goes straight into result.
          if (cyc_q == CYC_LAST) begin
            result_d = acc_q + ACC_W'(bus.in);
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc_d   = '0;
            cyc_d   = '0;
            state_d = bus.start ? RUN : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cyc_d   = '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule
